// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// start/busy/done handshake; bcd/overflow are registered and hold between conversions.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  dbg_state
);

  // Handshake: start is sampled only while idle (busy=0); a start seen while
  // busy=1 is dropped. done is a single-cycle pulse marking new bcd/overflow.
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_work;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_bcd;
  logic             r_overflow;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_next_work;
  logic [WIDTH-1:0] w_next_shift;
  logic             w_out_bit;

  // Digits are corrected independently; no carry crosses a digit boundary.
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
    end
    w_next_work  = {w_adj[BW-2:0], r_shift[WIDTH-1]};
    w_next_shift = {r_shift[WIDTH-2:0], 1'b0};
    w_out_bit    = w_adj[BW-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_work     <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= bin;
            r_work  <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_work  <= w_next_work;
          r_shift <= w_next_shift;
          r_ovf   <= r_ovf | w_out_bit;
          r_cnt   <= r_cnt - CNT_ONE;
          // Last bit: publish the result including this edge's shifted-out bit.
          if (r_cnt == CNT_ONE) begin
            r_bcd      <= w_next_work;
            r_overflow <= r_ovf | w_out_bit;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bcd       = r_bcd;
  assign overflow  = r_overflow;
  assign dbg_state = (r_state == CONV);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table, latency/handshake sequences,
// and a 4-digit instance for the overflow case.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy, done, overflow, dbg_state;
  logic [19:0] bcd;

  logic        start4;
  logic [15:0] bin4;
  logic        busy4, done4, overflow4, dbg_state4;
  logic [15:0] bcd4;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [19:0] prev_bcd;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec4_t;

  vec_t  vecs[5];
  vec4_t vecs4[2];

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .dbg_state(dbg_state)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(overflow4), .dbg_state(dbg_state4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every done on the 5-digit DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (bcd=%0h)", bcd);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check("result_bcd", {12'd0, bcd}, {12'd0, e[19:0]});
        check("result_ovf", {31'd0, overflow}, {31'd0, e[20]});
      end
    end
  end

  // Driver: one conversion on the 5-digit DUT, measuring latency and busy width.
  task automatic run_one(input logic [15:0] b, input logic [19:0] e_bcd, input logic e_ovf);
    int done_n = 0;
    int busy_n = 0;
    bit held_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    exp_q.push_back({e_ovf, e_bcd});
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        bin   = 16'($urandom_range(0, 65535));
        check("state_conv", {31'd0, dbg_state}, 32'd1);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n = n;
        break;
      end
      if (bcd !== prev_bcd) held_ok = 1'b0;
    end
    check("done_latency", done_n, 17);
    check("busy_cycles", busy_n, 16);
    check("bcd_held", {31'd0, held_ok}, 32'd1);
    prev_bcd = e_bcd;
  endtask

  task automatic run_four(input logic [15:0] b, input logic [15:0] e_bcd, input logic e_ovf);
    int done_n = 0;
    @(negedge clk);
    start4 = 1'b1;
    bin4   = b;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start4 = 1'b0;
        check("state_conv4", {31'd0, dbg_state4}, 32'd1);
      end
      if (done4) begin
        done_n = n;
        break;
      end
    end
    check("done_latency4", done_n, 17);
    check("bcd4", {16'd0, bcd4}, {16'd0, e_bcd});
    check("ovf4", {31'd0, overflow4}, {31'd0, e_ovf});
  endtask

  initial begin
    vecs[0] = '{16'd0,     20'h00000, 1'b0};
    vecs[1] = '{16'd9999,  20'h09999, 1'b0};
    vecs[2] = '{16'd12345, 20'h12345, 1'b0};
    vecs[3] = '{16'd65535, 20'h65535, 1'b0};
    vecs[4] = '{16'd65025, 20'h65025, 1'b0};
    vecs4[0] = '{16'd12345, 16'h2345, 1'b1};
    vecs4[1] = '{16'd9999,  16'h9999, 1'b0};

    reset = 1'b0; start = 1'b0; bin = '0; start4 = 1'b0; bin4 = '0;
    prev_bcd = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;

    // Table-driven basic and product-path values
    for (int i = 0; i < 5; i++) run_one(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

    // Reset mid-conversion: no done may follow.
    begin
      int dones = 0;
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd12345;
      @(posedge clk);
      for (int n = 1; n <= 7; n++) begin
        @(negedge clk);
        if (n == 1) start = 1'b0;
      end
      reset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_bcd", {12'd0, bcd}, 32'd0);
      check("midrst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (done || busy) dones++;
      end
      check("midrst_quiet", dones, 0);
      prev_bcd = '0;
    end

    // Start pulse while busy is ignored.
    begin
      int done_n = 0;
      int extra = 0;
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd4321;
      exp_q.push_back({1'b0, 20'h04321});
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        start = (n == 5);
        if (n == 5) bin = 16'd1;
        if (done) begin
          done_n = n;
          break;
        end
      end
      check("busy_start_latency", done_n, 17);
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("busy_start_ignored", extra, 0);
    end

    // Back-to-back with start held high.
    begin
      int done_at[3];
      int nd = 0;
      bit just_done = 1'b0;
      done_at = '{0, 0, 0};
      @(negedge clk);
      start = 1'b1;
      bin   = 16'd100;
      exp_q.push_back({1'b0, 20'h00100});
      exp_q.push_back({1'b0, 20'h00200});
      exp_q.push_back({1'b0, 20'h00300});
      @(posedge clk);
      for (int n = 1; n <= 80; n++) begin
        @(negedge clk);
        if (n == 1) bin = 16'd200;
        if (just_done) begin
          if (nd == 1) bin = 16'd300;
          if (nd == 2) start = 1'b0;
        end
        just_done = 1'b0;
        if (done && nd < 3) begin
          done_at[nd] = n;
          nd++;
          just_done = 1'b1;
          if (nd == 3) break;
        end
      end
      start = 1'b0;
      check("b2b_count", nd, 3);
      check("b2b_first", done_at[0], 17);
      check("b2b_gap1", done_at[1] - done_at[0], 17);
      check("b2b_gap2", done_at[2] - done_at[1], 17);
      repeat (20) @(negedge clk);
      check("b2b_queue_empty", exp_q.size(), 0);
    end

    // Four-digit instance: overflow then a value that fits.
    for (int i = 0; i < 2; i++) run_four(vecs4[i].bin, vecs4[i].bcd, vecs4[i].ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It sits between the 16-bit product/display-mux register and the per-digit seven-segment decoders. It replaces the combinational divide/modulo converter, trading WIDTH cycles of latency for a short critical path and lower LE count. A start/busy/done handshake lets the display controller request a conversion and then latch the digits.

Parameters:
WIDTH, 16, bit width of the unsigned binary input.
DIGITS, 5, number of BCD output digits; 4 bits per digit.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  conversion request; sampled only in IDLE.
bin  input  WIDTH  unsigned binary value; sampled on the accepting start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd/overflow are updated.
bcd  output  4*DIGITS  result; digit k in bits [4k+3:4k], digit 0 is least significant; holds until next done.
overflow  output  1  value does not fit in DIGITS digits; valid with bcd.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift/BCD work registers and counter=0. Applies immediately, including mid-conversion; the in-flight conversion is abandoned and produces no done.
- States: IDLE and CONV.
- IDLE: if start=1 at edge t0, then bin → binary shift register, BCD work register → 0, ovf work bit → 0, counter → WIDTH, busy → 1, state → CONV. If start=0, state holds. Only done clears to 0 on every edge where it is not being set.
- CONV, each edge: every work digit ≥5 gets +3 (4-bit, no carry between digits). Then {work digits, shift reg} shifts left 1 as one vector, MSB of shift reg entering digit 0 bit 0. The bit leaving the top digit ORs into the ovf work bit. Counter decrements.
- On the edge where counter goes 1→0 (edge t0+WIDTH): bcd ← final work digits, overflow ← ovf work bit (including that edge's shifted-out bit), done → 1 for exactly one cycle, busy → 0, state → IDLE.
- Latency: done high in the cycle after edge t0+WIDTH, i.e. WIDTH clocks after the start edge. busy is high for exactly WIDTH cycles.
- start while busy=1: ignored, not queued.
- start=1 in the cycle done=1: accepted, since state is already IDLE. Back-to-back conversions are every WIDTH+... exactly every WIDTH+0 cycles of busy plus one IDLE sampling edge. Throughput is one conversion per WIDTH+1 clocks with start held high.
- bin changes after the accepting edge: no effect on the current conversion.
- bcd/overflow change only on the done edge or on reset. They are stable at all other times, so downstream can read them without a handshake.
- Overflow: when DIGITS is too small, bcd = value mod 10^DIGITS and overflow=1. Defaults (16-bit, 5 digits) never overflow.
- Arithmetic: unsigned only. Counter width is clog2(WIDTH+1). No combinational path from inputs to outputs.

Test Plan:
- Reset mid-conversion: start with bin=16'd12345, assert reset at cycle 7 → busy=0, done=0, bcd=0, overflow=0 immediately; no done afterwards.
- Basic values with defaults: bin=0 → bcd=20'h00000; 9999 → 20'h09999; 12345 → 20'h12345; 65535 → 20'h65535. For each, done pulses exactly 16 cycles after the start edge, busy high for 16 cycles, overflow=0.
- Product path: bin=16'd65025 (255*255) → bcd=20'h65025. Prior bcd value stays held until the done cycle.
- Start during busy: start pulsed at cycle 5 with bin=16'd1 during a conversion of 16'd4321 → result 20'h04321, only one done, and no second conversion starts.
- Back-to-back: start held high with bin stepping 100, 200, 300 at each accept → three done pulses 17 cycles apart with bcd 20'h00100, 20'h00200, 20'h00300.
- Overflow: DIGITS=4, bin=16'd12345 → bcd=16'h2345, overflow=1. Then bin=16'd9999 → bcd=16'h9999, overflow=0.
